print_console: RTL and testbench
================================

# print_console

Output-side peer of the 16-bit single-cycle computer: it consumes the computer's print interface (`toDisplay` strobe, 16-bit `display` value) and the `finish` flag. Each printed value is buffered in a small FIFO, formatted as four uppercase hex ASCII digits plus a line feed, and shifted out on an 8N1 UART line. The computer has no stall input, so values that arrive while the FIFO is full are dropped and flagged. `done` reports that the program has exited and all of its output has left the wire.

## Interface
- `DEPTH`, 8, FIFO entries of 16 bits; power of two, at least 2.
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; the block is held in reset while low.
- `toDisplay`  in  1  print strobe; one value is offered per high cycle.
- `display`  in  16  value to print; sampled when `toDisplay` is high.
- `finish`  in  1  program-exit indication from the computer.
- `txd`  out  1  UART serial output; idle high.
- `busy`  out  1  high when the FIFO is non-empty, the formatter is not IDLE, or the transmitter is not idle.
- `done`  out  1  sticky; high once `finish` has been latched and the block has fully drained.
- `overflow`  out  1  sticky; high once any value has been dropped.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values:**
  - `txd`=1; `busy`, `done`, `overflow`, `level` = 0.
  - FIFO pointers cleared; formatter in IDLE; transmitter in IDLE; finish latch cleared.
- **FIFO write:** a value is written when `toDisplay`=1, the finish latch is clear, and either the FIFO is not full or a pop occurs in the same cycle.
- **Drop:** `toDisplay`=1 while the FIFO is full and no pop occurs in that cycle drops the value and sets `overflow`. `overflow` clears only on reset.
- **After finish:** `toDisplay` is ignored once the finish latch is set. A `toDisplay` in the same cycle as the first `finish` is still accepted.
- **Pointers:** read and write pointers wrap modulo `DEPTH`. `level` is computed from pointers that are one bit wider than the address.
- **Formatter states:**
  - IDLE: pop when the FIFO is non-empty, latch the word, go to SEND with char index 0.
  - SEND: present one character per byte; indices 0–3 are the nibbles [15:12], [11:8], [7:4], [3:0]; index 4 is 0x0A. After index 4 is accepted, return to IDLE.
- **Hex encoding:** nibble n maps to 0x30+n for n≤9 and to 0x37+n for n≥10 (uppercase A–F).
- **Transmitter states:** IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - A byte is accepted only in IDLE, via a valid/ready handshake.
- **done:** set when all of the following hold: finish latched, FIFO empty, formatter IDLE, transmitter IDLE. Once set, it stays high until reset.

## Timing
- **First byte:** `toDisplay` in cycle t into an empty, idle block gives:
  - pop at t+1;
  - byte handshake at t+2;
  - `txd` falls (start bit) at t+3.
- **Frame length:** 10·`CLKS_PER_BIT` cycles per byte.
- **Inter-byte gap:** exactly 1 idle cycle (`txd`=1) after every stop bit, including between consecutive values. Steady-state throughput is one value per 5·(10·`CLKS_PER_BIT`+1) cycles.
- **level:** updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- **Reset mid-frame:** `txd` returns to 1 asynchronously, all partially sent data is discarded, and no glitch frame is sent after release.
- **done latency:** `done` rises the cycle after the transmitter returns to IDLE from the last STOP. If `finish` arrives while the block is already drained, `done` rises the cycle after `finish`.

## Structure
- **Shared package** `print_console_pkg`:
  - ASCII constants `ASCII_0`=0x30, `ASCII_A_OFS`=0x37, `ASCII_LF`=0x0A;
  - formatter state enum;
  - transmitter state enum.
- **Sub-module** `uart_tx` (8N1, parameter `CLKS_PER_BIT`):
  - inputs: `clk`, `rst`, `data[7:0]`, `valid`;
  - outputs: `ready`, `txd`.
- The FIFO and formatter are inline in `print_console`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DEPTH`=8.
- **Single value:** one `toDisplay` with 0x1A2F → `txd` carries 0x31, 0x41, 0x32, 0x46, 0x0A, each framed as start + 8 data bits LSB-first + stop; 40 cycles per byte with a 1-cycle gap; `busy` falls after the final stop bit.
- **Boundary values:** back-to-back 0x0000 then 0xFFFF → "0000\n" then "FFFF\n"; `level` peaks at 1; no gap wider than 1 cycle between the two values.
- **Overflow:** 10 consecutive `toDisplay` cycles carrying 1..10 → value 1 is popped, values 2..9 fill the FIFO (`level`=8), value 10 is dropped and `overflow`=1. The output is "0001\n" … "0009\n" and never "000A\n".
- **Finish with data pending:** three values, then `finish` → `done` stays 0 until the last LF stop bit plus 1 cycle, then 1. A later `toDisplay` of 0x1234 is ignored and `level` stays 0.
- **Reset mid-frame:** `rst` low during the DATA bits of the second byte → `txd`=1 immediately and all outputs hold reset values. After release, an idle line shows no start bit until a new `toDisplay`.

Source files
------------

// File: rtl/print_console_pkg.sv
// print_console_pkg
// Shared constants and state types for the print console: ASCII codes used
// by the hex formatter, the formatter and UART transmitter state enums, and
// a nibble-to-ASCII helper.
package print_console_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;  // 'A' - 10
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic {
        FMT_IDLE,
        FMT_SEND
    } fmt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n <= 4'd9) return ASCII_0 + {4'h0, n};
        else           return ASCII_A_OFS + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter. One byte is taken per valid/ready handshake, which
// can only complete in IDLE; the frame is start bit, 8 data bits LSB first,
// stop bit, each CLKS_PER_BIT cycles long.
// Handshake: a byte transfers on a rising edge where valid && ready; the
// sender keeps data stable while valid is high and ready is low.
// Ports:
//   clk, rst (async active-low)
//   data[7:0], valid  - byte offered by the formatter
//   ready             - high in IDLE only
//   txd               - serial line, idle high, registered
module uart_tx
    import print_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          txd_nxt;
    logic          last_tick;

    assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            txd     <= txd_nxt;
        end
    end

    // txd is computed one cycle ahead so the line comes straight off a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        txd_nxt   = txd;
        ready     = (state == TX_IDLE);
        case (state)
            TX_IDLE: begin
                if (valid) begin
                    state_nxt = TX_START;
                    sh_nxt    = data;
                    cnt_nxt   = '0;
                    txd_nxt   = 1'b0;
                end
            end
            TX_START: begin
                if (last_tick) begin
                    state_nxt = TX_DATA;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    txd_nxt   = shreg[0];
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (last_tick) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = TX_STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        sh_nxt  = {1'b0, shreg[7:1]};
                        txd_nxt = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            TX_STOP: begin
                if (last_tick) begin
                    state_nxt = TX_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/print_console.sv
// print_console
// Print peripheral for the 16-bit computer. Each toDisplay value is queued
// in a FIFO, formatted as four uppercase hex digits plus LF and sent on an
// 8N1 UART. The computer cannot stall, so values arriving at a full FIFO are
// dropped and flagged.
// Ports:
//   clk, rst (async active-low)
//   toDisplay, display[15:0] - print strobe and value
//   finish                   - program exit; later prints are ignored
//   txd                      - UART line
//   busy                     - FIFO, formatter or transmitter has work
//   done                     - sticky: finished and fully drained
//   overflow                 - sticky: a value was dropped
//   level                    - FIFO occupancy
module print_console
    import print_console_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     toDisplay,
    input  logic [15:0]              display,
    input  logic                     finish,
    output logic                     txd,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // ---------------- FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr, rd_ptr;
    logic [15:0] mem [DEPTH];
    logic        empty, full, pop, offer, push, drop;
    logic        fin_q;

    fmt_state_t  fmt_state, fmt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [15:0] word;
    logic [7:0]  char;
    logic        tx_ready;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = (fmt_state == FMT_IDLE) && !empty;
    assign offer = toDisplay && !fin_q;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = offer && (!full || pop);
    assign drop  = offer && full && !pop;
    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= display;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word     <= '0;
            overflow <= 1'b0;
            fin_q    <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                word   <= mem[rd_ptr[AW-1:0]];
            end
            if (drop)   overflow <= 1'b1;
            if (finish) fin_q    <= 1'b1;
            // The raw finish input is included so an already-drained block
            // reports done on the very next cycle.
            if ((fin_q || finish) && empty && (fmt_state == FMT_IDLE) && tx_ready)
                done <= 1'b1;
        end
    end

    // ---------------- Formatter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fmt_state <= FMT_IDLE;
            idx       <= '0;
        end else begin
            fmt_state <= fmt_nxt;
            idx       <= idx_nxt;
        end
    end

    always_comb begin
        fmt_nxt = fmt_state;
        idx_nxt = idx;
        case (fmt_state)
            FMT_IDLE: begin
                if (!empty) begin
                    fmt_nxt = FMT_SEND;
                    idx_nxt = '0;
                end
            end
            FMT_SEND: begin
                if (tx_ready) begin
                    if (idx == 3'd4) fmt_nxt = FMT_IDLE;
                    else             idx_nxt = idx + 3'd1;
                end
            end
            default: fmt_nxt = FMT_IDLE;
        endcase
    end

    always_comb begin
        char = ASCII_LF;
        case (idx)
            3'd0:    char = hex_ascii(word[15:12]);
            3'd1:    char = hex_ascii(word[11:8]);
            3'd2:    char = hex_ascii(word[7:4]);
            3'd3:    char = hex_ascii(word[3:0]);
            default: char = ASCII_LF;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (char),
        .valid (fmt_state == FMT_SEND),
        .ready (tx_ready),
        .txd   (txd)
    );

    assign busy = !empty || (fmt_state != FMT_IDLE) || !tx_ready;

endmodule

// File: tb/tb_print_console.sv
module tb_print_console;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
  localparam int SLOT  = 10 * CPB + 1;
  localparam int MID   = CPB / 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        to_display = 1'b0;
  logic [15:0] display = 16'h0;
  logic        finish = 1'b0;
  logic        txd, busy, done, overflow;
  logic [3:0]  level;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  print_console #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .toDisplay (to_display),
    .display   (display),
    .finish    (finish),
    .txd       (txd),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .level     (level)
  );

  // ---------------- UART line monitor ----------------
  typedef struct {
    logic [7:0] b;
    int         start;
    int         gap;
    bit         ok;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] mon_sh;
  bit         mon_busy = 1'b0;
  bit         mon_ok;
  bit         have_prev = 1'b0;
  int         mon_cnt, mon_start, mon_gap, prev_start;

  always @(negedge clk) begin
    if (!rst) begin
      mon_busy  = 1'b0;
      have_prev = 1'b0;
    end else if (!mon_busy) begin
      if (!busy) have_prev = 1'b0;
      if (txd == 1'b0) begin
        mon_busy  = 1'b1;
        mon_cnt   = 0;
        mon_start = cyc;
        mon_ok    = 1'b1;
        mon_gap   = have_prev ? (cyc - prev_start) : -1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == MID && txd !== 1'b0) mon_ok = 1'b0;
      if (mon_cnt >= MID + CPB && mon_cnt <= MID + 8 * CPB && ((mon_cnt - MID) % CPB) == 0)
        mon_sh = {txd, mon_sh[7:1]};
      if (mon_cnt == MID + 9 * CPB) begin
        if (txd !== 1'b1) mon_ok = 1'b0;
        rx_q.push_back('{mon_sh, mon_start, mon_gap, mon_ok});
        prev_start = mon_start;
        have_prev  = 1'b1;
        mon_busy   = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         rx_rd = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drain_rx();
    rx_t r;
    while (rx_rd < rx_q.size()) begin
      r = rx_q[rx_rd];
      rx_rd++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %02h expected none (cycle %0d)", r.b, r.start);
      end else begin
        chk("rx_byte", 32'(r.b), 32'(exp_q.pop_front()));
      end
      chk("rx_framing", 32'(r.ok), 1);
      if (r.gap >= 0) chk("byte_spacing", r.gap, SLOT);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      drain_rx();
    end
  endtask

  task automatic send(input logic [15:0] v);
    to_display = 1'b1;
    display    = v;
    step(1);
    to_display = 1'b0;
  endtask

  task automatic expect_chars(input logic [39:0] s);
    for (int i = 4; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
  endtask

  // Waits for busy low with all expected bytes seen; returns the cycle.
  task automatic wait_idle(input string name, input int max, output int fall);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0 || mon_busy) && k < max) begin
      step(1);
      k++;
    end
    fall = cyc;
    chk({name, "_drained"}, 32'(k < max), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] v;
    logic [39:0] s;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test ----------------
  initial begin
    int n, fall, maxl, early, lows, base;

    vecs[0] = '{16'h1A2F, 40'h31_41_32_46_0A};
    vecs[1] = '{16'h9ABC, 40'h39_41_42_43_0A};
    vecs[2] = '{16'h5E07, 40'h35_45_30_37_0A};
    vecs[3] = '{16'h0F0A, 40'h30_46_30_41_0A};
    vecs[4] = '{16'h7C3D, 40'h37_43_33_44_0A};
    vecs[5] = '{16'hB6D8, 40'h42_36_44_38_0A};

    // reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_level", 32'(level), 0);
    step(3);
    rst = 1'b1;
    step(2);

    // single value: latency and busy fall
    n    = cyc;
    base = rx_q.size();
    expect_chars(40'h31_41_32_46_0A);
    send(16'h1A2F);
    chk("single_level_after_push", 32'(level), 1);
    step(1);
    chk("single_level_after_pop", 32'(level), 0);
    chk("single_busy", 32'(busy), 1);
    wait_idle("single", 400, fall);
    chk("single_busy_fall", fall, n + 2 + 5 * SLOT);
    if (rx_q.size() > base) chk("single_first_start", rx_q[base].start, n + 3);
    else chk("single_first_start_seen", 32'(rx_q.size()), 32'(base + 1));

    // boundary values back to back
    n = cyc;
    expect_chars(40'h30_30_30_30_0A);
    expect_chars(40'h46_46_46_46_0A);
    to_display = 1'b1;
    display    = 16'h0000;
    step(1);
    display    = 16'hFFFF;
    maxl       = int'(level);
    step(1);
    to_display = 1'b0;
    fall = 0;
    for (int k = 0; k < 600 && busy; k++) begin
      if (int'(level) > maxl) maxl = int'(level);
      step(1);
    end
    fall = cyc;
    chk("b2b_level_peak", maxl, 1);
    chk("b2b_busy_fall", fall, n + 2 + 10 * SLOT);
    wait_idle("b2b", 100, fall);

    // table-driven values
    for (int i = 0; i < 6; i++) begin
      expect_chars(vecs[i].s);
      send(vecs[i].v);
      wait_idle("vec", 400, fall);
    end

    // overflow: 10 consecutive strobes
    for (int i = 1; i <= 9; i++) expect_chars({32'h30_30_30_30 + 32'(i), 8'h0A});
    for (int i = 1; i <= 10; i++) begin
      to_display = 1'b1;
      display    = 16'(i);
      if (i == 10) begin
        chk("ovf_level_full", 32'(level), 8);
        chk("ovf_not_yet", 32'(overflow), 0);
      end
      step(1);
    end
    to_display = 1'b0;
    chk("ovf_level_after_drop", 32'(level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    wait_idle("ovf", 9 * 5 * SLOT + 100, fall);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_level_empty", 32'(level), 0);

    // reset during data bits of the second byte
    n = cyc;
    exp_q.push_back(8'h31);
    send(16'h1A2F);
    step(54);
    chk("midrst_first_byte_seen", 32'(exp_q.size()), 0);
    rst = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    step(3);
    rst  = 1'b1;
    lows = 0;
    for (int k = 0; k < 150; k++) begin
      step(1);
      if (txd !== 1'b1) lows++;
    end
    chk("midrst_idle_line", lows, 0);
    expect_chars(40'h30_30_34_32_0A);
    send(16'h0042);
    wait_idle("after_rst", 400, fall);

    // finish with data pending
    n = cyc;
    expect_chars(40'h30_31_32_33_0A);
    expect_chars(40'h34_35_36_37_0A);
    expect_chars(40'h38_39_41_42_0A);
    to_display = 1'b1;
    display    = 16'h0123;
    step(1);
    display    = 16'h4567;
    step(1);
    display    = 16'h89AB;
    step(1);
    to_display = 1'b0;
    finish     = 1'b1;
    step(1);
    finish = 1'b0;
    early  = 0;
    for (int k = 0; k < 800 && busy; k++) begin
      if (done) early++;
      step(1);
    end
    fall = cyc;
    chk("fin_no_early_done", early, 0);
    chk("fin_drain_cycle", fall, n + 2 + 15 * SLOT);
    chk("fin_done_low_at_idle", 32'(done), 0);
    step(1);
    chk("fin_done_rise", 32'(done), 1);
    send(16'h1234);
    chk("fin_ignored_level", 32'(level), 0);
    chk("fin_ignored_busy", 32'(busy), 0);
    step(60);
    chk("fin_done_sticky", 32'(done), 1);
    chk("fin_level_stays", 32'(level), 0);

    // finish while already drained
    do_reset();
    chk("drained_done_reset", 32'(done), 0);
    finish = 1'b1;
    step(1);
    finish = 1'b0;
    chk("drained_done_next", 32'(done), 1);

    // print in the same cycle as finish is kept; later ones are not
    do_reset();
    expect_chars(40'h30_30_46_46_0A);
    to_display = 1'b1;
    finish     = 1'b1;
    display    = 16'h00FF;
    step(1);
    finish = 1'b0;
    send(16'h0001);
    chk("same_cycle_level", 32'(level), 0);
    wait_idle("same_cycle", 400, fall);
    step(1);
    chk("same_cycle_done", 32'(done), 1);
    step(30);
    chk("final_exp_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
